// File: rtl/led_chain_transmitter.sv
// rtl/led_chain_transmitter.sv - LED-chain frame serialiser with latch gap; optional LED_CHAIN_TX_PENDING_EN queues a start seen while busy
module led_chain_transmitter #(
  parameter int NUM_LEDS     = 8,
  parameter int BITS_PER_LED = 24,
  parameter int LATCH_CYCLES = 64,
  localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  input  logic [NUM_LEDS*BITS_PER_LED-1:0] frames_in,
  input  logic                             bit_rqst,
  output logic                             bit_valid,
  output logic                             bit_out,
  output logic                             in_latch,
  output logic                             busy,
  output logic                             frame_done,
  output logic [LW-1:0]                    led_idx
);

  localparam int BW    = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam int CW    = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int TOTAL = NUM_LEDS * BITS_PER_LED;
  localparam int SW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

  state_t           r_state;
  logic [TOTAL-1:0] r_shadow;
  logic [BW-1:0]    r_bit_cnt;
  logic [LW-1:0]    r_led_idx;
  logic [CW-1:0]    r_latch_cnt;
  logic             r_bit_valid;
  logic             r_bit_out;
  logic             r_in_latch;
  logic             r_busy;
  logic             r_frame_done;

  logic             w_last_bit;
  logic [BW-1:0]    w_nxt_cnt;
  logic [LW-1:0]    w_nxt_led;
  logic [SW-1:0]    w_sel;
  logic             w_restart;

`ifdef LED_CHAIN_TX_PENDING_EN
  logic r_pending;
  // A start arriving on the very edge the gap ends still counts as seen while busy.
  assign w_restart = r_pending | start;
`else
  assign w_restart = 1'b0;
`endif

  always_comb begin
    w_last_bit = (r_bit_cnt == '0) && (r_led_idx == LW'(NUM_LEDS - 1));
    w_nxt_cnt  = (r_bit_cnt == '0) ? BW'(BITS_PER_LED - 1) : r_bit_cnt - BW'(1);
    w_nxt_led  = (r_bit_cnt == '0) ? r_led_idx + LW'(1) : r_led_idx;
    w_sel      = SW'(w_nxt_led) * SW'(BITS_PER_LED) + SW'(w_nxt_cnt);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_shadow     <= '0;
      r_bit_cnt    <= '0;
      r_led_idx    <= '0;
      r_latch_cnt  <= '0;
      r_bit_valid  <= 1'b0;
      r_bit_out    <= 1'b0;
      r_in_latch   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef LED_CHAIN_TX_PENDING_EN
      r_pending    <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
`ifdef LED_CHAIN_TX_PENDING_EN
      if (start && (r_state != ST_IDLE)) r_pending <= 1'b1;
`endif
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shadow    <= frames_in;
            r_bit_cnt   <= BW'(BITS_PER_LED - 1);
            r_led_idx   <= '0;
            r_state     <= ST_SHIFT;
            r_bit_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_bit_out   <= frames_in[BITS_PER_LED-1];
          end
        end
        ST_SHIFT: begin
          if (bit_rqst) begin
            if (w_last_bit) begin
              r_state     <= ST_LATCH;
              r_bit_valid <= 1'b0;
              r_bit_out   <= 1'b0;
              r_in_latch  <= 1'b1;
              r_latch_cnt <= CW'(LATCH_CYCLES - 1);
            end else begin
              r_bit_cnt <= w_nxt_cnt;
              r_led_idx <= w_nxt_led;
              r_bit_out <= r_shadow[w_sel];
            end
          end
        end
        ST_LATCH: begin
          if (r_latch_cnt == '0) begin
            r_in_latch   <= 1'b0;
            r_frame_done <= 1'b1;
            if (w_restart) begin
              // Back-to-back frame set: skip IDLE and present the new LED0 MSB now.
              r_shadow    <= frames_in;
              r_bit_cnt   <= BW'(BITS_PER_LED - 1);
              r_led_idx   <= '0;
              r_state     <= ST_SHIFT;
              r_bit_valid <= 1'b1;
              r_bit_out   <= frames_in[BITS_PER_LED-1];
`ifdef LED_CHAIN_TX_PENDING_EN
              r_pending   <= 1'b0;
`endif
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_latch_cnt <= r_latch_cnt - CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bit_valid  = r_bit_valid;
  assign bit_out    = r_bit_out;
  assign in_latch   = r_in_latch;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign led_idx    = r_led_idx;

endmodule

// File: tb/tb_led_chain_transmitter.sv
// tb/tb_led_chain_transmitter.sv - randomized self-checking bench for led_chain_transmitter (small and full-size instances)
module tb_led_chain_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic         s_start, s_rqst, s_valid, s_bit, s_latch, s_busy, s_done;
  logic [7:0]   s_frames;
  logic [0:0]   s_led;

  logic         b_start, b_rqst, b_valid, b_bit, b_latch, b_busy, b_done;
  logic [191:0] b_frames;
  logic [2:0]   b_led;

  led_chain_transmitter #(.NUM_LEDS(2), .BITS_PER_LED(4), .LATCH_CYCLES(3)) u_small (
    .clk(clk), .rstn(rstn), .start(s_start), .frames_in(s_frames), .bit_rqst(s_rqst),
    .bit_valid(s_valid), .bit_out(s_bit), .in_latch(s_latch), .busy(s_busy),
    .frame_done(s_done), .led_idx(s_led)
  );

  led_chain_transmitter #(.NUM_LEDS(8), .BITS_PER_LED(24), .LATCH_CYCLES(64)) u_big (
    .clk(clk), .rstn(rstn), .start(b_start), .frames_in(b_frames), .bit_rqst(b_rqst),
    .bit_valid(b_valid), .bit_out(b_bit), .in_latch(b_latch), .busy(b_busy),
    .frame_done(b_done), .led_idx(b_led)
  );

  int n_checks = 0;
  int n_errs   = 0;
  bit exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference order: LED0 first, MSB first within each LED.
  task automatic build_exp(input logic [191:0] frames, input int n, input int b);
    exp_q.delete();
    for (int led = 0; led < n; led++)
      for (int bt = b - 1; bt >= 0; bt--)
        exp_q.push_back(frames[led*b + bt]);
  endtask

  task automatic s_run(input logic [7:0] fr, input logic [7:0] fr_after,
                       input int gmin, input int gmax, input bit junk,
                       input int abort_after, input bit busy_start);
    int gap, cnt;
    build_exp({184'b0, fr}, 2, 4);
    s_frames = fr;
    s_start  = 1'b1;
    tick;
    s_start  = 1'b0;
    s_frames = fr_after;
    check("s_start_valid", s_valid, 1);
    check("s_start_busy", s_busy, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_after) begin
        rstn = 1'b0;
        #1;
        check("s_rst_valid", s_valid, 0);
        check("s_rst_bit", s_bit, 0);
        check("s_rst_busy", s_busy, 0);
        check("s_rst_latch", s_latch, 0);
        check("s_rst_led", s_led, 0);
        tick;
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
          tick;
          check("s_rst_no_done", s_done, 0);
        end
        return;
      end
      check("s_bit", s_bit, exp_q[i]);
      check("s_valid", s_valid, 1);
      check("s_led", s_led, i / 4);
      if (busy_start && i == 2) begin
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        check("s_busy_start_hold", s_bit, exp_q[i]);
      end
      gap = $urandom_range(gmax, gmin);
      for (int g = 0; g < gap; g++) begin
        tick;
        check("s_gap_bit", s_bit, exp_q[i]);
      end
      s_rqst = 1'b1;
      tick;
      s_rqst = 1'b0;
    end
    check("s_latch_enter", s_latch, 1);
    check("s_latch_valid", s_valid, 0);
    check("s_latch_bit", s_bit, 0);
    cnt = 1;
    for (int k = 0; k < 12 && s_latch; k++) begin
      s_rqst = junk ? 1'($urandom_range(1, 0)) : 1'b0;
      tick;
      if (s_latch) cnt++;
    end
    s_rqst = 1'b0;
    check("s_latch_len", cnt, 3);
    check("s_done_pulse", s_done, 1);
`ifdef LED_CHAIN_TX_PENDING_EN
    if (busy_start) begin
      check("s_pend_valid", s_valid, 1);
      check("s_pend_bit", s_bit, fr_after[3]);
      check("s_pend_busy", s_busy, 1);
      rstn = 1'b0;
      tick;
      rstn = 1'b1;
      tick;
      return;
    end
`endif
    check("s_done_busy", s_busy, 0);
    tick;
    check("s_done_once", s_done, 0);
    check("s_idle_valid", s_valid, 0);
    check("s_idle_busy", s_busy, 0);
  endtask

  task automatic big_run;
    logic [191:0] f2, f3;
    int n, cnt;
    for (int j = 0; j < 6; j++) begin
      b_frames[j*32 +: 32] = $urandom;
      f2[j*32 +: 32]       = $urandom;
      f3[j*32 +: 32]       = $urandom;
    end
    build_exp(b_frames, 8, 24);
    b_rqst  = 1'b1;
    b_start = 1'b1;
    tick;
    b_start  = 1'b0;
    b_frames = f2;
    n = 0;
    while (b_valid && n < 300) begin
      if (n < 192) begin
        check("b_bit", b_bit, exp_q[n]);
        check("b_led", b_led, n / 24);
      end
      n++;
      tick;
    end
    check("b_nbits", n, 192);
    cnt = 0;
    while (b_latch && cnt < 100) begin
      cnt++;
      tick;
    end
    check("b_latch_len", cnt, 64);
    check("b_done", b_done, 1);
    b_frames = f3;
    b_start  = 1'b1;
    tick;
    b_start = 1'b0;
    b_rqst  = 1'b0;
    check("b_restart_valid", b_valid, 1);
    check("b_restart_busy", b_busy, 1);
    check("b_restart_bit", b_bit, f3[23]);
    check("b_restart_led", b_led, 0);
  endtask

  initial begin
    rstn = 1'b0;
    s_start = 1'b0; s_rqst = 1'b0; s_frames = '0;
    b_start = 1'b0; b_rqst = 1'b0; b_frames = '0;
    tick;
    tick;
    check("rst_s_valid", s_valid, 0);
    check("rst_s_bit", s_bit, 0);
    check("rst_s_latch", s_latch, 0);
    check("rst_s_busy", s_busy, 0);
    check("rst_s_done", s_done, 0);
    check("rst_s_led", s_led, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_led", b_led, 0);
    rstn = 1'b1;
    tick;

    for (int k = 0; k < 4; k++) begin
      s_rqst = 1'b1;
      tick;
      check("idle_rqst_valid", s_valid, 0);
      check("idle_rqst_busy", s_busy, 0);
    end
    s_rqst = 1'b0;

    s_run(8'hA5, 8'hA5, 3, 3, 1'b0, 99, 1'b0);
    tick;
    s_run(8'hA5, 8'hFF, 0, 2, 1'b1, 99, 1'b0);
    for (int r = 0; r < 4; r++)
      s_run(8'($urandom), 8'($urandom), 0, 3, 1'($urandom_range(1, 0)), 99, 1'b0);

    s_run(8'($urandom), 8'($urandom), 0, 1, 1'b0, 5, 1'b0);
    s_run(8'($urandom), 8'($urandom), 0, 1, 1'b0, 99, 1'b0);

    s_run(8'($urandom), 8'($urandom), 0, 1, 1'b0, 99, 1'b1);
    tick;

    big_run();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
